// File: rtl/sequenciador_soma_serial.sv
// sequenciador_soma_serial: adds two W-bit operands one nibble per clock by
// driving an external 4-bit ripple-carry adder, LS nibble first. The carry is
// kept in a register between nibbles and the result has a start/busy/done
// handshake.
// Optional feature: define SEQ_SUB_EN to add the `sub` port. With sub=1 the
// block computes op_a - op_b (B inverted, carry-in forced to 1).
module sequenciador_soma_serial #(
    parameter int NIBBLES = 4,
    localparam int W  = 4 * NIBBLES,
    localparam int IW = $clog2(NIBBLES)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         cin_ext,
`ifdef SEQ_SUB_EN
    input  logic         sub,
`endif
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout,
    output logic [3:0]   add_a,
    output logic [3:0]   add_b,
    output logic         add_cin,
    input  logic [3:0]   add_sum,
    input  logic         add_cout
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state;
    logic [NIBBLES-1:0][3:0] a_q;
    logic [NIBBLES-1:0][3:0] b_q;
    logic [NIBBLES-1:0][3:0] res_q;
    logic [IW-1:0]           idx;
    logic                    carry;
    logic                    cout_q;
    logic [W-1:0]            b_in;
    logic                    c_in;
    logic                    run;
    logic                    last;

    // Operand conditioning at capture time: subtraction is A + ~B + 1.
`ifdef SEQ_SUB_EN
    assign b_in = sub ? ~op_b : op_b;
    assign c_in = sub ? 1'b1  : cin_ext;
`else
    assign b_in = op_b;
    assign c_in = cin_ext;
`endif

    assign run  = (state == RUN);
    assign last = (idx == IW'(NIBBLES - 1));

    // Nibble mux to the adder; quiet zeros whenever no nibble is in flight.
    assign add_a   = run ? a_q[idx] : 4'h0;
    assign add_b   = run ? b_q[idx] : 4'h0;
    assign add_cin = run ? carry    : 1'b0;

    // Handshake flags are plain decodes of the state register.
    assign busy   = run;
    assign done   = (state == DONE);
    assign result = res_q;
    assign cout   = cout_q;

    // Sequencer: capture operands on start, walk idx across the nibbles,
    // store each adder slice and thread the carry through the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            res_q  <= '0;
            cout_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_q   <= op_a;
                        b_q   <= b_in;
                        carry <= c_in;
                        idx   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    res_q[idx] <= add_sum;
                    carry      <= add_cout;
                    if (last) begin
                        // idx stays parked at the top nibble; it is cleared on the next start.
                        cout_q <= add_cout;
                        state  <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
